// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider FSM states and the
// quotient reported for a divide by zero.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the CPU control path (master) and the
// iterative divider (slave).
interface seq_divider_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic             enable;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output enable, a, b,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  enable, a, b,
        output q, r, busy, done, div_zero
    );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] pr_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] pr_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    // The held remainder is always < divisor, so only the shifted value needs
    // the extra bit; the difference always fits back into WIDTH bits.
    always_comb begin
        shifted = {pr_i, msb_i};
        if (shifted >= {1'b0, divisor_i}) begin
            pr_o   = shifted[WIDTH-1:0] - divisor_i;
            qbit_o = 1'b1;
        end else begin
            pr_o   = shifted[WIDTH-1:0];
            qbit_o = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Results and the divide-by-zero flag hold until the next accepted start.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] step_pr;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr_i      (pr_q),
        .msb_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .pr_o      (step_pr),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (bus.enable) begin
                    if (bus.b == '0) begin
                        state_d = DIV_DONE;
                        q_d     = '1;
                        r_d     = bus.a;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = DIV_RUN;
                        dvd_d   = bus.a;
                        dvs_d   = bus.b;
                        pr_d    = '0;
                        count_d = '0;
                        dz_d    = 1'b0;
                    end
                end
            end
            DIV_RUN: begin
                // Quotient bits fill the dividend register from the LSB as its MSBs are consumed.
                dvd_d   = {dvd_q[WIDTH-2:0], step_qbit};
                pr_d    = step_pr;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DIV_DONE;
                    q_d     = {dvd_q[WIDTH-2:0], step_qbit};
                    r_d     = step_pr;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q == DIV_RUN);
    assign bus.done     = (state_q == DIV_DONE);
    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle-level arithmetic model checked
// every cycle, plus directed cases with hand-computed results.
module tb_seq_divider;
    import alu_pkg::*;

    localparam int W = ALU_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a pending result appears W clocks after acceptance.
    int           m_rem = 0;
    logic         m_done = 1'b0;
    logic         m_dz = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_rem = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1; m_q = p_q; m_r = p_r;
                end
            end else if (bus.enable) begin
                if (bus.b == 0) begin
                    m_done = 1'b1; m_q = '1; m_r = bus.a; m_dz = 1'b1;
                end else begin
                    m_rem = W; p_q = bus.a / bus.b; p_r = bus.a % bus.b; m_dz = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", bus.busy, m_rem > 0);
            check("model_done", bus.done, m_done);
            check("model_q", bus.q, m_q);
            check("model_r", bus.r, m_r);
            check("model_dz", bus.div_zero, m_dz);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.enable = 1'b1; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.enable = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 0; nbusy = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) check("done_timeout", bus.done, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, nb, seen;
        logic [W-1:0] ta [3], tb [3], tq [3], tr [3];
        logic [W-1:0] ra, rb;
        logic [31:0]  recon;

        bus.enable = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_q", bus.q, 0);
        check("rst_r", bus.r, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz", bus.div_zero, 0);
        rst = 1'b1;
        @(negedge clk);

        // 100 / 7
        start(16'd100, 16'd7);
        wait_done(c, nb);
        check("t1_latency", c, 16);
        check("t1_busy_cycles", nb, 16);
        check("t1_q", bus.q, 14);
        check("t1_r", bus.r, 2);
        check("t1_dz", bus.div_zero, 0);
        @(negedge clk);
        check("t1_done_pulse", bus.done, 0);

        // Boundary operands
        ta = '{16'hFFFF, 16'd5, 16'd0};
        tb = '{16'd1, 16'hFFFF, 16'd3};
        tq = '{16'hFFFF, 16'd0, 16'd0};
        tr = '{16'd0, 16'd5, 16'd0};
        for (int i = 0; i < 3; i++) begin
            start(ta[i], tb[i]);
            wait_done(c, nb);
            check("t2_q", bus.q, tq[i]);
            check("t2_r", bus.r, tr[i]);
        end

        // Divide by zero
        @(negedge clk);
        start(16'd1234, 16'd0);
        wait_done(c, nb);
        check("t3_latency", c, 0);
        check("t3_busy_cycles", nb, 0);
        check("t3_q", bus.q, 16'hFFFF);
        check("t3_r", bus.r, 16'd1234);
        check("t3_dz", bus.div_zero, 1);

        // Enable while busy is dropped; enable during DONE is accepted
        start(16'd50, 16'd3);
        repeat (5) @(negedge clk);
        bus.enable = 1'b1; bus.a = 16'd9; bus.b = 16'd2;
        @(negedge clk);
        bus.enable = 1'b0;
        wait_done(c, nb);
        check("t4_q", bus.q, 16);
        check("t4_r", bus.r, 2);
        check("t4_dz", bus.div_zero, 0);
        bus.enable = 1'b1; bus.a = 16'd200; bus.b = 16'd9;
        @(negedge clk);
        check("t4_b2b_busy", bus.busy, 1);
        bus.enable = 1'b0;
        wait_done(c, nb);
        check("t4_b2b_q", bus.q, 22);
        check("t4_b2b_r", bus.r, 2);

        // Reset mid-run aborts
        start(16'd1000, 16'd7);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", bus.busy, 0);
        check("t5_done", bus.done, 0);
        check("t5_q", bus.q, 0);
        check("t5_r", bus.r, 0);
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("t5_no_done", seen, 0);
        start(16'd77, 16'd5);
        wait_done(c, nb);
        check("t5_q_after", bus.q, 15);
        check("t5_r_after", bus.r, 2);

        // Random operands
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 65535));
            rb = (i % 4 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 65535));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start(ra, rb);
            wait_done(c, nb);
            recon = 32'(bus.q) * 32'(rb) + 32'(bus.r);
            check("t6_identity", recon, 32'(ra));
            check("t6_r_lt_b", bus.r < rb, 1);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
